fw_guard_engine: RTL and testbench
==================================

// Module: fw_guard_engine
// PURPOSE
//  Parametrised next-generation bus firewall core. Inspects each bus transaction for three violations:
//  - protected-range write
//  - programmable signature match
//  - repeated-data flood
//  On any violation it raises an alert, drives a timed lockout FSM and logs the cause.
//  Sits between the bus master port and the protected peripheral; the top level gates traffic with firewall_block.
// PARAMETERS
//  DATA_W      32     transaction data width (8..64)
//  ADDR_W      16     transaction address width
//  NUM_SIG     4      signature table entries (1..13)
//  REPEAT_TH   3      consecutive identical valid data words that constitute a flood (>=2)
//  LOCK_CYCLES 20     base lockout length in clk cycles (>=1)
//  CNT_W       8      violation counter width
//  PROT_LO     16'h1000  reset value of protected-range low bound (inclusive)
//  PROT_HI     16'h1FFF  reset value of protected-range high bound (inclusive)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-low
//  data_in      in   DATA_W  transaction data
//  addr         in   ADDR_W  transaction address
//  wr_en        in   1       write strobe
//  rd_en        in   1       read strobe
//  cfg_we       in   1       config write strobe
//  cfg_addr     in   4       config select: 0..NUM_SIG-1 sig entry, D valid mask, E prot_lo, F prot_hi
//  cfg_wdata    in   DATA_W  config write data
//  clr_cnt      in   1       clears viol_cnt
//  alert_out    out  1       one-cycle pulse per violating transaction
//  firewall_block out 1      high in ALERT and LOCKOUT
//  led_status   out  2       01 MONITOR, 10 ALERT, 11 LOCKOUT
//  viol_code    out  3       {repeat,sig,rule} of most recent violation, held
//  viol_cnt     out  CNT_W   saturating count of violating transactions
//  pass_out     out  1       registered: previous transaction admitted clean
// BEHAVIOUR
//  Reset values: state MONITOR, led_status=01, all other outputs 0, run counter 0, prot_lo/hi=PROT_LO/PROT_HI.
//  Signature reset state: entry0=32'hCAFEBABE, entry1=32'h0000BEEF (truncated to DATA_W); entries 0,1 valid, rest invalid.
//  Valid transaction: wr_en|rd_en. Both high = treated as a write.
//  Checks, all evaluated in the same cycle the transaction is presented:
//  - rule: write && prot_lo<=addr<=prot_hi (unsigned).
//  - sig: data_in equals any valid entry.
//  - repeat: the previous valid data register and run count update on valid only.
//    - Equal data -> run+1, saturating at REPEAT_TH; otherwise run=1.
//    - Flag when run reaches/holds REPEAT_TH, i.e. the 3rd, 4th, ... identical word.
//    - Idle cycles do not break a run.
//  Latency 1: violation at edge N -> at N+1 alert_out=1, viol_code updated, viol_cnt+1, state ALERT.
//  FSM:
//  - MONITOR -> ALERT on violation.
//  - ALERT (exactly 1 cycle) -> LOCKOUT.
//  - LOCKOUT lasts exactly L cycles (timer loaded L-1, exits at 0), then -> MONITOR.
//  - L=LOCK_CYCLES unless FW_ESCALATE_EN.
//  Violation during ALERT/LOCKOUT: still pulses alert_out, updates code/count, reloads timer (lockout restarts).
//  pass_out=1 at N+1 iff the transaction at N was valid, clean, and state at N was MONITOR.
//  viol_cnt saturates at all-ones. clr_cnt with simultaneous violation -> viol_cnt=1.
//  Config:
//  - Config write takes effect next cycle; a same-cycle transaction is checked with the old config.
//  - Sig-entry write sets its valid bit. cfg_addr D sets the valid mask = cfg_wdata[NUM_SIG-1:0].
//  - Unmapped cfg_addr values are ignored.
//  - prot_lo>prot_hi -> range empty, no rule violations.
//  Reset mid-lockout returns to MONITOR immediately; counters, run state and config return to reset values.
// CONFIGURATION
//  FW_ESCALATE_EN defined:
//  - 2-bit esc_level; L = LOCK_CYCLES<<esc_level.
//  - esc_level increments, saturating at 3, on each MONITOR->ALERT occurring within 4*LOCK_CYCLES cycles of the last LOCKOUT exit.
//  - Clears to 0 after 4*LOCK_CYCLES consecutive clean MONITOR cycles.
//  - esc_level resets to 0.
//  FW_ESCALATE_EN undefined: L fixed at LOCK_CYCLES; no escalation logic is synthesised.
// TESTING (defaults, 50 MHz)
//  1. Read addr 16'h1000 data 32'h12345678 -> pass_out=1 next cycle, alert_out=0, led_status=01.
//  2. Write addr 16'h1234 data 32'h00000001 -> alert_out pulse, viol_code=001, block=1 for 21 cycles (ALERT+20), then led=01.
//  3. Read data 32'hCAFEBABE, then cfg D mask 0 and repeat the read after lockout -> first viol_code=010, second clean.
//  4. Three reads of 32'hAAAA5555 with idle gap between 2nd and 3rd -> only the 3rd alerts, viol_code=100.
//  5. Write 16'h1234 data 32'h0000BEEF during LOCKOUT cycle 10 -> viol_code=011, viol_cnt+1, LOCKOUT restarts at full length.
//  6. FW_ESCALATE_EN: two rule violations 10 cycles after first lockout exit -> second lockout 40 cycles; rst low mid-lockout -> led=01 next cycle.

Source files
------------

// File: rtl/fw_guard_if.sv
// Transaction, configuration and status bundle between a bus source and fw_guard_engine.
// The master modport is the side that drives transactions; the slave modport is the firewall.
interface fw_guard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              clr_cnt;
  logic              alert_out;
  logic              firewall_block;
  logic [1:0]        led_status;
  logic [2:0]        viol_code;
  logic [CNT_W-1:0]  viol_cnt;
  logic              pass_out;

  modport master (
    output data_in, addr, wr_en, rd_en, cfg_we, cfg_addr, cfg_wdata, clr_cnt,
    input  alert_out, firewall_block, led_status, viol_code, viol_cnt, pass_out
  );

  modport slave (
    input  data_in, addr, wr_en, rd_en, cfg_we, cfg_addr, cfg_wdata, clr_cnt,
    output alert_out, firewall_block, led_status, viol_code, viol_cnt, pass_out
  );
endinterface

// File: rtl/fw_guard_engine.sv
// Bus firewall: flags protected-range writes, signature hits and repeated-data floods, then locks out.
// Optional macro FW_ESCALATE_EN doubles the lockout length for repeat offenders (up to 8x).
module fw_guard_engine #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 16,
  parameter int              NUM_SIG     = 4,
  parameter int              REPEAT_TH   = 3,
  parameter int              LOCK_CYCLES = 20,
  parameter int              CNT_W       = 8,
  parameter logic [ADDR_W-1:0] PROT_LO   = 16'h1000,
  parameter logic [ADDR_W-1:0] PROT_HI   = 16'h1FFF
) (
  input logic       clk,
  input logic       rst,
  fw_guard_if.slave bus
);

  localparam int RUN_W = $clog2(REPEAT_TH + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES * 8 + 1);

  // State encoding doubles as the LED pattern.
  typedef enum logic [1:0] {
    ST_MONITOR = 2'b01,
    ST_ALERT   = 2'b10,
    ST_LOCKOUT = 2'b11
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v == RUN_W'(REPEAT_TH)) ? v : v + RUN_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMR_W-1:0]   lock_load;
  logic [DATA_W-1:0]  sig_q [NUM_SIG];
  logic [DATA_W-1:0]  sig_d [NUM_SIG];
  logic [NUM_SIG-1:0] sig_vld_q, sig_vld_d;
  logic [ADDR_W-1:0]  prot_lo_q, prot_lo_d, prot_hi_q, prot_hi_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               alert_q, alert_d;
  logic               pass_q, pass_d;
  logic [2:0]         code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic valid, rule_hit, sig_hit, rep_hit, viol;

  // Stage 0: all three checks on the presented transaction against current config.
  always_comb begin
    valid    = bus.wr_en | bus.rd_en;
    rule_hit = bus.wr_en && (bus.addr >= prot_lo_q) && (bus.addr <= prot_hi_q);
    sig_hit  = 1'b0;
    for (int i = 0; i < NUM_SIG; i++) begin
      if (sig_vld_q[i] && (bus.data_in == sig_q[i])) sig_hit = 1'b1;
    end
    prev_d = prev_q;
    run_d  = run_q;
    if (valid) begin
      prev_d = bus.data_in;
      // run_q==0 only before the first valid word, so reset data never counts as a match.
      if ((run_q != '0) && (bus.data_in == prev_q)) run_d = run_sat_inc(run_q);
      else                                          run_d = RUN_W'(1);
    end
    rep_hit = valid && (run_d == RUN_W'(REPEAT_TH));
    viol    = valid && (rule_hit || sig_hit || rep_hit);
  end

  always_comb begin
    sig_d     = sig_q;
    sig_vld_d = sig_vld_q;
    prot_lo_d = prot_lo_q;
    prot_hi_d = prot_hi_q;
    if (bus.cfg_we) begin
      for (int i = 0; i < NUM_SIG; i++) begin
        if (bus.cfg_addr == 4'(i)) begin
          sig_d[i]     = bus.cfg_wdata;
          sig_vld_d[i] = 1'b1;
        end
      end
      case (bus.cfg_addr)
        4'hD:    sig_vld_d = NUM_SIG'(bus.cfg_wdata);
        4'hE:    prot_lo_d = ADDR_W'(bus.cfg_wdata);
        4'hF:    prot_hi_d = ADDR_W'(bus.cfg_wdata);
        default: ;
      endcase
    end
  end

  always_comb begin
    alert_d = viol;
    pass_d  = valid && !viol && (state_q == ST_MONITOR);
    code_d  = viol ? {rep_hit, sig_hit, rule_hit} : code_q;
    cnt_d   = cnt_q;
    if (bus.clr_cnt) cnt_d = viol ? CNT_W'(1) : '0;
    else if (viol)   cnt_d = cnt_sat_inc(cnt_q);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_MONITOR: ;
      ST_ALERT: begin
        state_d = ST_LOCKOUT;
        timer_d = lock_load;
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) state_d = ST_MONITOR;
        else               timer_d = timer_q - TMR_W'(1);
      end
      default: state_d = ST_MONITOR;
    endcase
    // Any violation, even mid-lockout, restarts the whole ALERT/LOCKOUT sequence.
    if (viol) state_d = ST_ALERT;
  end

`ifdef FW_ESCALATE_EN
  localparam int WIN   = 4 * LOCK_CYCLES;
  localparam int WIN_W = $clog2(WIN + 1);

  logic [1:0]       esc_q, esc_d;
  logic             win_act_q, win_act_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] clean_q, clean_d;

  always_comb begin
    esc_d     = esc_q;
    win_act_d = win_act_q;
    win_cnt_d = win_cnt_q;
    clean_d   = clean_q;
    // Window opens on each lockout exit and stays open for WIN cycles.
    if ((state_q == ST_LOCKOUT) && (timer_q == '0) && !viol) begin
      win_act_d = 1'b1;
      win_cnt_d = '0;
    end else if (win_act_q) begin
      if (win_cnt_q == WIN_W'(WIN - 1)) win_act_d = 1'b0;
      else                              win_cnt_d = win_cnt_q + WIN_W'(1);
    end
    if ((state_q == ST_MONITOR) && viol && win_act_q && (esc_q != 2'd3)) esc_d = esc_q + 2'd1;
    if ((state_q == ST_MONITOR) && !viol) begin
      if (clean_q == WIN_W'(WIN - 1)) begin
        esc_d   = 2'd0;
        clean_d = '0;
      end else begin
        clean_d = clean_q + WIN_W'(1);
      end
    end else begin
      clean_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      esc_q     <= 2'd0;
      win_act_q <= 1'b0;
      win_cnt_q <= '0;
      clean_q   <= '0;
    end else begin
      esc_q     <= esc_d;
      win_act_q <= win_act_d;
      win_cnt_q <= win_cnt_d;
      clean_q   <= clean_d;
    end
  end

  assign lock_load = TMR_W'((LOCK_CYCLES << esc_q) - 1);
`else
  assign lock_load = TMR_W'(LOCK_CYCLES - 1);
`endif

  // Stage 1: registered results, one cycle after the transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_MONITOR;
      timer_q   <= '0;
      for (int i = 0; i < NUM_SIG; i++) sig_q[i] <= '0;
      sig_q[0]  <= DATA_W'(32'hCAFEBABE);
      if (NUM_SIG > 1) sig_q[NUM_SIG > 1 ? 1 : 0] <= DATA_W'(32'h0000BEEF);
      sig_vld_q <= NUM_SIG'(2'b11);
      prot_lo_q <= PROT_LO;
      prot_hi_q <= PROT_HI;
      prev_q    <= '0;
      run_q     <= '0;
      alert_q   <= 1'b0;
      pass_q    <= 1'b0;
      code_q    <= 3'b000;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sig_q     <= sig_d;
      sig_vld_q <= sig_vld_d;
      prot_lo_q <= prot_lo_d;
      prot_hi_q <= prot_hi_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      alert_q   <= alert_d;
      pass_q    <= pass_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.alert_out      = alert_q;
  assign bus.pass_out       = pass_q;
  assign bus.viol_code      = code_q;
  assign bus.viol_cnt       = cnt_q;
  assign bus.led_status     = state_q;
  assign bus.firewall_block = (state_q != ST_MONITOR);

endmodule

// File: tb/tb_fw_guard_engine.sv
// Directed bench for fw_guard_engine (default parameters, escalation disabled).
module tb_fw_guard_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  always #10 clk = ~clk;

  fw_guard_if #(.DATA_W(32), .ADDR_W(16), .CNT_W(8)) bus ();

  fw_guard_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [31:0] data;
    logic        exp_alert;
    logic [2:0]  exp_code;
  } vec_t;

  vec_t vt [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.rd_en = 0; bus.addr = '0; bus.data_in = '0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.clr_cnt = 0;
  endtask

  task automatic xact(input logic wr, input logic rd, input logic [15:0] a, input logic [31:0] d);
    bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.data_in = d;
    tick();
    idle();
  endtask

  task automatic cfg(input logic [3:0] a, input logic [31:0] d);
    bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick(); tick();
    rst = 1;
    exp_cnt = 0;
  endtask

  // Called right after a violating edge: 1 ALERT cycle, exactly 20 LOCKOUT cycles, then MONITOR.
  task automatic lock_seq(input string nm);
    chk({nm, "_led_alert"}, bus.led_status, 2'b10);
    chk({nm, "_blk_alert"}, bus.firewall_block, 1'b1);
    tick();
    chk({nm, "_led_lock1"}, bus.led_status, 2'b11);
    repeat (19) tick();
    chk({nm, "_led_lock20"}, bus.led_status, 2'b11);
    tick();
    chk({nm, "_led_mon"}, bus.led_status, 2'b01);
    chk({nm, "_blk_mon"}, bus.firewall_block, 1'b0);
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 16'h1000, 32'h12345678, 1'b0, 3'b000};
    vt[1]  = '{1'b1, 1'b0, 16'h1234, 32'h00000001, 1'b1, 3'b001};
    vt[2]  = '{1'b1, 1'b0, 16'h0FFF, 32'h00000002, 1'b0, 3'b001};
    vt[3]  = '{1'b1, 1'b0, 16'h1000, 32'h00000003, 1'b1, 3'b001};
    vt[4]  = '{1'b1, 1'b0, 16'h1FFF, 32'h00000004, 1'b1, 3'b001};
    vt[5]  = '{1'b1, 1'b0, 16'h2000, 32'h00000005, 1'b0, 3'b001};
    vt[6]  = '{1'b1, 1'b1, 16'h1500, 32'h00000006, 1'b1, 3'b001};
    vt[7]  = '{1'b0, 1'b1, 16'h0000, 32'hCAFEBABE, 1'b1, 3'b010};
    vt[8]  = '{1'b0, 1'b1, 16'h0000, 32'h0000BEEF, 1'b1, 3'b010};
    vt[9]  = '{1'b1, 1'b0, 16'h1234, 32'h0000BEEF, 1'b1, 3'b011};
    vt[10] = '{1'b0, 1'b1, 16'h0040, 32'hAAAA5555, 1'b0, 3'b011};
    vt[11] = '{1'b0, 1'b1, 16'h0040, 32'hAAAA5555, 1'b0, 3'b011};
    vt[12] = '{1'b0, 1'b1, 16'h0040, 32'hAAAA5555, 1'b1, 3'b100};
    vt[13] = '{1'b0, 1'b1, 16'h0040, 32'hAAAA5555, 1'b1, 3'b100};
    vt[14] = '{1'b0, 1'b1, 16'h0040, 32'h11111111, 1'b0, 3'b100};
    vt[15] = '{1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 3'b100};

    idle();
    rst = 0;
    tick(); tick();
    chk("rst_led", bus.led_status, 2'b01);
    chk("rst_blk", bus.firewall_block, 1'b0);
    chk("rst_alert", bus.alert_out, 1'b0);
    chk("rst_pass", bus.pass_out, 1'b0);
    chk("rst_code", bus.viol_code, 3'b000);
    chk("rst_cnt", bus.viol_cnt, 8'd0);
    rst = 1;
    exp_cnt = 0;
    tick();

    for (int i = 0; i < 16; i++) begin
      xact(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data);
      if (vt[i].exp_alert) exp_cnt++;
      chk($sformatf("v%0d_alert", i), bus.alert_out, vt[i].exp_alert);
      chk($sformatf("v%0d_code", i), bus.viol_code, vt[i].exp_code);
      chk($sformatf("v%0d_pass", i), bus.pass_out, (vt[i].wr | vt[i].rd) & ~vt[i].exp_alert);
      chk($sformatf("v%0d_cnt", i), bus.viol_cnt, exp_cnt);
      if (vt[i].exp_alert) lock_seq($sformatf("v%0d", i));
      else chk($sformatf("v%0d_led", i), bus.led_status, 2'b01);
    end

    // Signature masking and config timing.
    do_reset();
    xact(0, 1, 16'h0, 32'hCAFEBABE);
    chk("sig_code", bus.viol_code, 3'b010);
    lock_seq("sig");
    cfg(4'hD, 32'h0);
    xact(0, 1, 16'h0, 32'hCAFEBABE);
    chk("mask_alert", bus.alert_out, 1'b0);
    chk("mask_pass", bus.pass_out, 1'b1);
    bus.cfg_we = 1; bus.cfg_addr = 4'h2; bus.cfg_wdata = 32'hDEADBEEF;
    xact(0, 1, 16'h0, 32'hDEADBEEF);
    chk("sig2_old_alert", bus.alert_out, 1'b0);
    chk("sig2_old_pass", bus.pass_out, 1'b1);
    xact(0, 1, 16'h0, 32'hDEADBEEF);
    chk("sig2_new_alert", bus.alert_out, 1'b1);
    chk("sig2_new_code", bus.viol_code, 3'b010);
    lock_seq("sig2");
    bus.cfg_we = 1; bus.cfg_addr = 4'hE; bus.cfg_wdata = 32'h1600;
    xact(1, 0, 16'h1500, 32'h55);
    chk("lo_old_alert", bus.alert_out, 1'b1);
    chk("lo_old_code", bus.viol_code, 3'b001);
    lock_seq("lo_old");
    xact(1, 0, 16'h1500, 32'h56);
    chk("lo_new_pass", bus.pass_out, 1'b1);
    cfg(4'hE, 32'h2000);
    xact(1, 0, 16'h1FFF, 32'h57);
    chk("empty_hi_alert", bus.alert_out, 1'b0);
    xact(1, 0, 16'h2000, 32'h58);
    chk("empty_lo_alert", bus.alert_out, 1'b0);
    cfg(4'hA, 32'h59);
    xact(0, 1, 16'h0, 32'h59);
    chk("unmapped_alert", bus.alert_out, 1'b0);
    chk("unmapped_pass", bus.pass_out, 1'b1);

    // Violation during lockout restarts the full lockout.
    do_reset();
    xact(1, 0, 16'h1234, 32'h1);
    exp_cnt = 1;
    chk("rl_first_alert", bus.alert_out, 1'b1);
    tick();
    xact(0, 1, 16'h0, 32'h12121212);
    chk("rl_lock_pass", bus.pass_out, 1'b0);
    chk("rl_lock_alert", bus.alert_out, 1'b0);
    chk("rl_lock_led", bus.led_status, 2'b11);
    repeat (7) tick();
    xact(1, 0, 16'h1234, 32'h0000BEEF);
    exp_cnt = 2;
    chk("rl_alert", bus.alert_out, 1'b1);
    chk("rl_code", bus.viol_code, 3'b011);
    chk("rl_cnt", bus.viol_cnt, exp_cnt);
    lock_seq("rl");

    // Counter clear interaction and saturation.
    bus.clr_cnt = 1;
    xact(1, 0, 16'h1234, 32'h7);
    chk("clr_viol_cnt", bus.viol_cnt, 8'd1);
    lock_seq("clr");
    bus.clr_cnt = 1;
    tick();
    idle();
    chk("clr_cnt", bus.viol_cnt, 8'd0);
    for (int i = 0; i < 260; i++) begin
      bus.wr_en = 1; bus.addr = 16'h1234; bus.data_in = 32'(i + 1000);
      tick();
    end
    idle();
    chk("sat_cnt", bus.viol_cnt, 8'hFF);
    chk("sat_alert", bus.alert_out, 1'b1);
    lock_seq("sat");

    // Reset mid-lockout restores state, counters and config.
    cfg(4'hD, 32'h0);
    xact(1, 0, 16'h1234, 32'h9);
    repeat (5) tick();
    chk("mid_led_lock", bus.led_status, 2'b11);
    rst = 0;
    tick();
    chk("mid_rst_led", bus.led_status, 2'b01);
    chk("mid_rst_blk", bus.firewall_block, 1'b0);
    chk("mid_rst_cnt", bus.viol_cnt, 8'd0);
    chk("mid_rst_code", bus.viol_code, 3'b000);
    rst = 1;
    tick();
    xact(0, 1, 16'h0, 32'hCAFEBABE);
    chk("mid_sig_restored", bus.alert_out, 1'b1);
    chk("mid_sig_code", bus.viol_code, 3'b010);
    xact(1, 0, 16'h1FFF, 32'h3);
    chk("mid_prot_restored", bus.viol_code, 3'b001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
